// File: rtl/uart_rx_if.sv
// Device bus bundle for the UART receiver: request/address/write
// fields from the core, and a registered read response back to it.
interface uart_rx_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output rvalid, rdata
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserialiser (8E1 when UART_RX_PARITY_EN is defined),
// RX FIFO and memory-mapped RXDATA/STATUS/LEVEL registers on the device bus.
// Ports: clk_i, rst_i (sync, active high), bus (uart_rx_if.slave),
// uart_rx_i (async serial line, idle high), rx_irq_o (FIFO non-empty).
module uart_rx #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 8
) (
  input  logic      clk_i,
  input  logic      rst_i,
  uart_rx_if.slave  bus,
  input  logic      uart_rx_i,
  output logic      rx_irq_o
);

  localparam int Cpb = ClockFrequency / BaudRate;
  localparam int Tw  = $clog2(Cpb);
  localparam int Pw  = $clog2(FifoDepth);
  localparam int Cw  = $clog2(FifoDepth + 1);

  localparam logic [Tw-1:0] BitLast  = Tw'(Cpb - 1);
  localparam logic [Tw-1:0] HalfLast = Tw'(Cpb / 2 - 1);
  localparam logic [Cw-1:0] Depth    = Cw'(FifoDepth);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [Tw-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  logic sync1, sync2, sync_d;
  logic fall;

  logic [7:0]    mem [FifoDepth];
  logic [Pw-1:0] wr_ptr, rd_ptr;
  logic [Cw-1:0] count, count_nxt;
  logic          overrun, frame_err, parity_err;

  logic        bit_done, stop_tick, par_bad;
  logic        push, push_ok, pop, ovf;
  logic        par_fail, frame_fail;
  logic        empty, full;
  logic        sel_data, sel_stat, sel_lvl;
  logic        stat_wr;
  logic [31:0] rd_val;
  logic        unused;

  assign unused = ^{bus.be, bus.wdata[31:5],
                    bus.wdata[1:0], bus.addr[31:4],
                    bus.addr[1:0]};

  // Two-flop synchroniser plus one stage for edge detect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= uart_rx_i;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign fall = sync_d & ~sync2;

  always_comb begin
    bit_done  = (timer == BitLast);
    stop_tick = (state == STOP) && bit_done;
`ifdef UART_RX_PARITY_EN
    // Even parity: data plus parity bit must XOR to 0.
    par_bad = ^{shift, par_bit};
`else
    par_bad = 1'b0;
`endif
    push       = stop_tick & sync2 & ~par_bad;
    par_fail   = stop_tick & sync2 & par_bad;
    frame_fail = stop_tick & ~sync2;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            timer   <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (timer == HalfLast) begin
            timer <= '0;
            // A high mid-start sample is a glitch.
            state <= sync2 ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer   <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            timer   <= '0;
            par_bit <= sync2;
            state   <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == Depth);

  assign sel_data = (bus.addr[3:2] == 2'd0);
  assign sel_stat = (bus.addr[3:2] == 2'd1);
  assign sel_lvl  = (bus.addr[3:2] == 2'd2);

  assign pop     = bus.req & ~bus.we & sel_data & ~empty;
  assign stat_wr = bus.req & bus.we & sel_stat;
  // A pop in the same cycle frees the slot for the push.
  assign push_ok = push & (~full | pop);
  assign ovf     = push & full & ~pop;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_data: rd_val = empty ? 32'd0
                       : {24'd0, mem[rd_ptr]};
      sel_stat: rd_val = {27'd0, parity_err,
                          frame_err, overrun,
                          full, empty};
      sel_lvl:  rd_val = 32'(count);
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      rx_irq_o   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_nxt;
      rx_irq_o <= (count_nxt != '0);
      // W1C; a set in the same cycle wins.
      overrun <= ovf | (overrun &
                 ~(stat_wr & bus.wdata[2]));
      frame_err <= frame_fail | (frame_err &
                   ~(stat_wr & bus.wdata[3]));
      parity_err <= par_fail | (parity_err &
                    ~(stat_wr & bus.wdata[4]));
      bus.rvalid <= bus.req;
      if (bus.req) begin
        bus.rdata <= bus.we ? 32'd0 : rd_val;
      end
    end
  end

endmodule
